// File: rtl/gearbox_64b_66b_rx.sv
// Receive gearbox: splits a 32-bit GT word stream into 66b blocks, each presented
// as a 2-bit sync header with the first payload word, then the second payload word.
module gearbox_64b_66b_rx (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] data_i,
    input  logic        slip_i,
    output logic [31:0] data_o,
    output logic [1:0]  head_o,
    output logic        head_valid_o
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned HEAD_W = 2;
    localparam int unsigned BUF_W  = 66;
    localparam int unsigned CNT_W  = 7;

    localparam logic [0:0] PH_HEAD = 1'b0;
    localparam logic [0:0] PH_BODY = 1'b1;

    logic [BUF_W-1:0]  buf_q, buf_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [0:0]        phase_q, phase_d;
    logic              slip_pend_q, slip_pend_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic [HEAD_W-1:0] head_q, head_d;
    logic              head_valid_q, head_valid_d;

    logic [BUF_W-1:0]  ext;
    logic [CNT_W-1:0]  avail;

    // Append the new word after the buffered bits, then slip/extract by phase.
    always_comb begin
        buf_d        = buf_q;
        cnt_d        = cnt_q;
        phase_d      = phase_q;
        slip_pend_d  = slip_pend_q;
        data_d       = data_q;
        head_d       = head_q;
        head_valid_d = 1'b0;

        ext   = (buf_q & ~({BUF_W{1'b1}} << cnt_q)) | (BUF_W'(data_i) << cnt_q);
        avail = cnt_q + CNT_W'(WORD_W);

        if (phase_q == PH_HEAD) begin
            if (slip_pend_q || slip_i) begin
                ext         = ext >> 1;
                avail       = avail - CNT_W'(1);
                slip_pend_d = 1'b0;
            end
            if (avail >= CNT_W'(WORD_W + HEAD_W)) begin
                head_d       = ext[HEAD_W-1:0];
                data_d       = ext[WORD_W+HEAD_W-1:HEAD_W];
                head_valid_d = 1'b1;
                ext          = ext >> (WORD_W + HEAD_W);
                avail        = avail - CNT_W'(WORD_W + HEAD_W);
                phase_d      = PH_BODY;
            end
        end else begin
            // Body word never stalls; a slip seen here waits for the next header.
            data_d      = ext[WORD_W-1:0];
            ext         = ext >> WORD_W;
            avail       = avail - CNT_W'(WORD_W);
            slip_pend_d = slip_pend_q | slip_i;
            phase_d     = PH_HEAD;
        end

        buf_d = ext;
        cnt_d = avail;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            buf_q        <= '0;
            cnt_q        <= '0;
            phase_q      <= PH_HEAD;
            slip_pend_q  <= 1'b0;
            data_q       <= '0;
            head_q       <= '0;
            head_valid_q <= 1'b0;
        end else begin
            buf_q        <= buf_d;
            cnt_q        <= cnt_d;
            phase_q      <= phase_d;
            slip_pend_q  <= slip_pend_d;
            data_q       <= data_d;
            head_q       <= head_d;
            head_valid_q <= head_valid_d;
        end
    end

    assign data_o       = data_q;
    assign head_o       = head_q;
    assign head_valid_o = head_valid_q;

endmodule

// File: tb/tb_gearbox_64b_66b_rx.sv
// Self-checking bench for gearbox_64b_66b_rx: directed block streams plus random
// data/slip/reset traffic compared against a bit-queue reference model.
module tb_gearbox_64b_66b_rx;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] data_i = '0;
    logic        slip_i = 1'b0;
    logic [31:0] data_o;
    logic [1:0]  head_o;
    logic        head_valid_o;

    gearbox_64b_66b_rx dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .data_i       (data_i),
        .slip_i       (slip_i),
        .data_o       (data_o),
        .head_o       (head_o),
        .head_valid_o (head_valid_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference model: a plain queue of received line bits.
    bit          mq[$];
    bit          m_body;
    bit          m_pend;
    logic [31:0] m_data;
    logic [1:0]  m_head;
    logic        m_hv;

    task automatic mdl_step(input logic [31:0] d, input logic s, input logic r);
        if (r) begin
            mq.delete();
            m_body = 0; m_pend = 0;
            m_data = '0; m_head = '0; m_hv = 1'b0;
            return;
        end
        for (int i = 0; i < 32; i++) mq.push_back(d[i]);
        m_hv = 1'b0;
        if (!m_body) begin
            if (m_pend || s) begin
                void'(mq.pop_front());
                m_pend = 0;
            end
            if (mq.size() >= 34) begin
                m_head = {mq[1], mq[0]};
                for (int i = 0; i < 32; i++) m_data[i] = mq[2+i];
                for (int i = 0; i < 34; i++) void'(mq.pop_front());
                m_hv   = 1'b1;
                m_body = 1;
            end
        end else begin
            for (int i = 0; i < 32; i++) m_data[i] = mq[i];
            for (int i = 0; i < 32; i++) void'(mq.pop_front());
            m_pend = m_pend | s;
            m_body = 0;
        end
    endtask

    // Source of 66b blocks: header 01 (first bit 1), fixed payload, LSB first.
    bit src[$];
    localparam logic [63:0] PAYLOAD = 64'h0123456789ABCDEF;

    task automatic next_word(output logic [31:0] w);
        while (src.size() < 32) begin
            src.push_back(1'b1);
            src.push_back(1'b0);
            for (int i = 0; i < 64; i++) src.push_back(PAYLOAD[i]);
        end
        for (int i = 0; i < 32; i++) w[i] = src.pop_front();
    endtask

    task automatic cyc(input logic [31:0] d, input logic s, input logic r);
        @(negedge clk);
        data_i = d; slip_i = s; rst_i = r;
        mdl_step(d, s, r);
        @(posedge clk);
        #1;
        check("model_data", 64'(data_o), 64'(m_data));
        check("model_head", 64'(head_o), 64'(m_head));
        check("model_hv",   64'(head_valid_o), 64'(m_hv));
    endtask

    logic [31:0] w;
    int          pulses;
    bit          prev_hv;
    bit          exp_hv_pat;

    initial begin
        mdl_step('0, 1'b0, 1'b1);

        // Reset held with random data
        for (int i = 0; i < 3; i++) begin
            cyc($urandom, 1'b0, 1'b1);
            check("rst_data", 64'(data_o), 64'd0);
            check("rst_head", 64'(head_o), 64'd0);
            check("rst_hv",   64'(head_valid_o), 64'd0);
        end

        // Aligned stream: cadence, first block, idle hold
        src.delete();
        pulses = 0;
        for (int k = 0; k < 66; k++) begin
            next_word(w);
            cyc(w, 1'b0, 1'b0);
            exp_hv_pat = ((k % 33) != 0) && ((((k % 33) - 1) % 2) == 0);
            check("cadence_hv", 64'(head_valid_o), 64'(exp_hv_pat));
            if (head_valid_o) pulses++;
            if (k == 1) begin
                check("first_head", 64'(head_o), 64'h1);
                check("first_w0",   64'(data_o), 64'h89ABCDEF);
            end
            if (k == 2) check("first_w1", 64'(data_o), 64'h01234567);
            if (k > 0 && (k % 33) == 0) begin
                check("idle_data", 64'(data_o), 64'h01234567);
                check("idle_head", 64'(head_o), 64'h1);
            end
        end
        check("pulse_count", 64'(pulses), 64'd32);

        // Mid-run reset on a body cycle
        next_word(w); cyc(w, 1'b0, 1'b0);   // idle
        next_word(w); cyc(w, 1'b0, 1'b0);   // head
        check("pre_rst_hv", 64'(head_valid_o), 64'd1);
        next_word(w); cyc(w, 1'b0, 1'b1);   // would be body
        check("mid_rst_data", 64'(data_o), 64'd0);
        check("mid_rst_head", 64'(head_o), 64'd0);
        check("mid_rst_hv",   64'(head_valid_o), 64'd0);
        src.delete();
        next_word(w); cyc(w, 1'b0, 1'b0);
        check("restart_idle", 64'(head_valid_o), 64'd0);
        next_word(w); cyc(w, 1'b0, 1'b0);
        check("restart_hv",   64'(head_valid_o), 64'd1);
        check("restart_head", 64'(head_o), 64'h1);
        check("restart_w0",   64'(data_o), 64'h89ABCDEF);
        next_word(w); cyc(w, 1'b0, 1'b0);
        check("restart_w1",   64'(data_o), 64'h01234567);

        // Slip: stream offset by one bit, slip pulsed on a body cycle
        cyc($urandom, 1'b0, 1'b1);
        src.delete();
        src.push_back(1'($urandom_range(0, 1)));
        next_word(w); cyc(w, 1'b0, 1'b0);   // idle
        next_word(w); cyc(w, 1'b0, 1'b0);   // misaligned head
        next_word(w); cyc(w, 1'b1, 1'b0);   // body, slip pending
        prev_hv = 0;
        for (int k = 0; k < 40; k++) begin
            next_word(w);
            cyc(w, 1'b0, 1'b0);
            if (k == 0) check("slip_first_hv", 64'(head_valid_o), 64'd1);
            if (m_hv) begin
                check("slip_head", 64'(head_o), 64'h1);
                check("slip_w0",   64'(data_o), 64'h89ABCDEF);
            end else if (prev_hv) begin
                check("slip_w1",   64'(data_o), 64'h01234567);
            end
            prev_hv = m_hv;
        end

        // Random data, slips and occasional resets against the model
        for (int k = 0; k < 1500; k++) begin
            cyc($urandom, 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 199) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
